// File: rtl/mul_issue_ctrl.sv
// Execute-stage issue controller for the multicycle multiplier: launches a
// multiply, stalls the pipeline while it runs, and returns one RV64 writeback beat.
module mul_issue_ctrl #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 64
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                MulValid,
    input  logic [DATA_W-1:0]   MulRs1Data,
    input  logic [DATA_W-1:0]   MulRs2Data,
    input  logic [4:0]          MulRdAddr,
    input  logic [6:0]          MulOpCode,
    input  logic [2:0]          MulFunct3,
    input  logic [6:0]          MulFunct7,
    input  logic                Flush,
    output logic [1:0]          MulHoldFlag,
    output logic [DATA_W-1:0]   MulitiplicandOut,
    output logic [DATA_W-1:0]   MulitiplierOut,
    output logic [4:0]          MulRdAddrOut,
    output logic [6:0]          MulOpCodeOut,
    output logic [2:0]          MulFunct3Out,
    output logic [6:0]          MulFunct7Out,
    input  logic [2*DATA_W-1:0] ProductIn,
    input  logic                MulHoldEndIn,
    input  logic [4:0]          MulWriteAddrIn,
    input  logic [6:0]          MulOpCodeIn,
    input  logic [2:0]          MulFunct3In,
    output logic                StallReq,
    output logic                WbValid,
    output logic [4:0]          WbAddr,
    output logic [DATA_W-1:0]   WbData,
    output logic                MulTimeoutErr,
    output logic [2:0]          state_dbg
);

    localparam logic [6:0] OP_OP   = 7'b0110011;
    localparam logic [6:0] OP_OP32 = 7'b0111011;
    localparam logic [6:0] F7_MUL  = 7'b0000001;
    localparam int         CNT_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               is_mul, accept, capture, timeout_hit;
    logic               sel_ok, res_ok;
    logic [DATA_W-1:0]  sel_data, res_data;
    logic [4:0]         res_addr;

    assign is_mul = (MulOpCode == OP_OP || MulOpCode == OP_OP32) && (MulFunct7 == F7_MUL);
    assign accept = (state == S_IDLE) && MulValid && !Flush && is_mul;

    // Handshake: the multiplier sees a one-cycle 01 start code, then 10 until
    // it answers with a single-cycle MulHoldEndIn pulse carrying the product.
    always_comb begin
        state_next  = state;
        MulHoldFlag = 2'b00;
        StallReq    = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_START;
                    StallReq   = 1'b1;
                end
            end
            S_START: begin
                MulHoldFlag = 2'b01;
                StallReq    = 1'b1;
                state_next  = S_WAIT;
            end
            S_WAIT: begin
                MulHoldFlag = 2'b10;
                StallReq    = 1'b1;
                if (Flush) begin
                    // A product arriving with the flush is simply dropped.
                    state_next = MulHoldEndIn ? S_IDLE : S_DRAIN;
                end else if (MulHoldEndIn) begin
                    state_next = S_DONE;
                    capture    = 1'b1;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_next  = S_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            S_DRAIN: begin
                MulHoldFlag = 2'b10;
                if (MulHoldEndIn) state_next = S_IDLE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        sel_ok   = 1'b0;
        sel_data = '0;
        if (MulOpCodeIn == OP_OP) begin
            case (MulFunct3In)
                3'b000: begin
                    sel_ok   = 1'b1;
                    sel_data = ProductIn[DATA_W-1:0];
                end
                3'b001, 3'b010, 3'b011: begin
                    sel_ok   = 1'b1;
                    sel_data = ProductIn[2*DATA_W-1:DATA_W];
                end
                default: ;
            endcase
        end else if (MulOpCodeIn == OP_OP32 && MulFunct3In == 3'b000) begin
            sel_ok   = 1'b1;
            sel_data = {{(DATA_W-32){ProductIn[31]}}, ProductIn[31:0]};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state            <= S_IDLE;
            cnt              <= '0;
            MulitiplicandOut <= '0;
            MulitiplierOut   <= '0;
            MulRdAddrOut     <= '0;
            MulOpCodeOut     <= '0;
            MulFunct3Out     <= '0;
            MulFunct7Out     <= '0;
            res_ok           <= 1'b0;
            res_data         <= '0;
            res_addr         <= '0;
            MulTimeoutErr    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= (state == S_WAIT) ? cnt + 1'b1 : '0;
            if (accept) begin
                MulitiplicandOut <= MulRs1Data;
                MulitiplierOut   <= MulRs2Data;
                MulRdAddrOut     <= MulRdAddr;
                MulOpCodeOut     <= MulOpCode;
                MulFunct3Out     <= MulFunct3;
                MulFunct7Out     <= MulFunct7;
            end
            if (capture) begin
                res_ok   <= sel_ok;
                res_data <= sel_data;
                res_addr <= MulWriteAddrIn;
            end
            if (timeout_hit) MulTimeoutErr <= 1'b1;
        end
    end

    // Writeback is visible only during DONE; rd = x0 suppresses the beat.
    assign WbValid   = (state == S_DONE) && res_ok && (res_addr != 5'd0);
    assign WbAddr    = (state == S_DONE) ? res_addr : 5'd0;
    assign WbData    = (state == S_DONE) ? res_data : '0;
    assign state_dbg = state;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: acts as the multiplier, predicts writebacks from
// RV64 M-extension arithmetic, and scores them from a separate monitor.
module tb_mul_issue_ctrl;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 64;
    localparam logic [6:0] OP   = 7'b0110011;
    localparam logic [6:0] OP32 = 7'b0111011;
    localparam logic [6:0] F7M  = 7'b0000001;

    logic         clk, rst_n, mul_valid, flush, end_in;
    logic [63:0]  rs1, rs2;
    logic [4:0]   rd_addr, wr_addr;
    logic [6:0]   opcode, funct7, op_in;
    logic [2:0]   funct3, f3_in;
    logic [127:0] product;
    logic [1:0]   hold_flag;
    logic [63:0]  mcand_out, mplier_out, wb_data;
    logic [4:0]   rd_out, wb_addr;
    logic [6:0]   op_out, f7_out;
    logic [2:0]   f3_out, state_dbg;
    logic         stall, wb_valid, tmo_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [68:0] exp_q[$];
    logic [63:0] last_wb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mul_issue_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk(clk), .Rst(rst_n), .MulValid(mul_valid),
        .MulRs1Data(rs1), .MulRs2Data(rs2), .MulRdAddr(rd_addr),
        .MulOpCode(opcode), .MulFunct3(funct3), .MulFunct7(funct7),
        .Flush(flush), .MulHoldFlag(hold_flag),
        .MulitiplicandOut(mcand_out), .MulitiplierOut(mplier_out),
        .MulRdAddrOut(rd_out), .MulOpCodeOut(op_out),
        .MulFunct3Out(f3_out), .MulFunct7Out(f7_out),
        .ProductIn(product), .MulHoldEndIn(end_in),
        .MulWriteAddrIn(wr_addr), .MulOpCodeIn(op_in), .MulFunct3In(f3_in),
        .StallReq(stall), .WbValid(wb_valid), .WbAddr(wb_addr), .WbData(wb_data),
        .MulTimeoutErr(tmo_err), .state_dbg(state_dbg)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full 2*XLEN product as the multiplier would return it for each funct3.
    function automatic logic [127:0] prod(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] x, y;
        x = (f3 == 3'b011) ? {64'b0, a} : {{64{a[63]}}, a};
        y = (f3 == 3'b010 || f3 == 3'b011) ? {64'b0, b} : {{64{b[63]}}, b};
        return x * y;
    endfunction

    // Architectural result of the instruction, or ok = 0 if it has none.
    task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, output logic ok, output logic [63:0] d);
        logic [127:0] p;
        logic [31:0]  w;
        ok = 1'b0;
        d  = 64'd0;
        p  = prod(f3, a, b);
        if (op == OP && f3 == 3'b000) begin
            ok = 1'b1;
            d  = a * b;
        end else if (op == OP && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011)) begin
            ok = 1'b1;
            d  = p[127:64];
        end else if (op == OP32 && f3 == 3'b000) begin
            ok = 1'b1;
            w  = a[31:0] * b[31:0];
            d  = {{32{w[31]}}, w};
        end
    endtask

    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wb_unexpected: got addr %0h data %0h expected no beat", wb_addr, wb_data);
            end else begin
                logic [68:0] e;
                e = exp_q.pop_front();
                check("wb_addr", 128'(wb_addr), 128'(e[68:64]));
                check("wb_data", 128'(wb_data), 128'(e[63:0]));
                last_wb = wb_data;
            end
        end
    end

    task automatic issue(input logic [4:0] rd, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [63:0] a, input logic [63:0] b);
        mul_valid = 1'b1;
        rd_addr   = rd;
        opcode    = op;
        funct3    = f3;
        funct7    = f7;
        rs1       = a;
        rs2       = b;
    endtask

    task automatic launch(input logic [4:0] rd, input logic [6:0] op, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] b);
        issue(rd, op, f3, F7M, a, b);
        @(negedge clk);
        check("accept_stall", 128'(stall), 128'(1));
        tick;
        mul_valid = 1'b0;
        @(negedge clk);
        check("start_flags", 128'({hold_flag, stall}), 128'(3'b011));
        check("operands", {mcand_out, mplier_out}, {a, b});
        check("op_fields", 128'({rd_out, op_out, f3_out, f7_out}), 128'({rd, op, f3, F7M}));
        tick;
    endtask

    task automatic do_op(input logic [4:0] rd, input logic [6:0] op, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b, input int lat);
        logic        ok;
        logic [63:0] d;
        launch(rd, op, f3, a, b);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("wait_flags", 128'({hold_flag, stall}), 128'(3'b101));
            tick;
        end
        model(op, f3, a, b, ok, d);
        if (ok && rd != 5'd0) exp_q.push_back({rd, d});
        end_in  = 1'b1;
        product = prod(f3, a, b);
        wr_addr = rd;
        op_in   = op;
        f3_in   = f3;
        @(negedge clk);
        check("wait_flags", 128'({hold_flag, stall}), 128'(3'b101));
        tick;
        end_in  = 1'b0;
        product = '0;
        @(negedge clk);
        check("done_flags", 128'({hold_flag, stall}), 128'(3'b000));
        tick;
        check("wb_pending", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic flush_op(input int k, input bit with_end);
        launch(5'd9, OP, 3'b000, 64'd3, 64'd4);
        repeat (k) tick;
        product = prod(3'b000, 64'd3, 64'd4);
        wr_addr = 5'd9;
        op_in   = OP;
        f3_in   = 3'b000;
        flush   = 1'b1;
        end_in  = with_end;
        tick;
        flush  = 1'b0;
        end_in = 1'b0;
        if (!with_end) begin
            issue(5'd10, OP, 3'b000, F7M, 64'd5, 64'd6);
            @(negedge clk);
            check("drain_flags", 128'({hold_flag, stall}), 128'(3'b100));
            tick;
            mul_valid = 1'b0;
            @(negedge clk);
            check("drain_no_accept", 128'(hold_flag), 128'(2'b10));
            end_in = 1'b1;
            tick;
            end_in = 1'b0;
        end
        @(negedge clk);
        check("flush_idle", 128'({hold_flag, stall}), 128'(3'b000));
        tick;
    endtask

    task automatic reject(input logic [6:0] op, input logic [6:0] f7, input logic fl);
        issue(5'd3, op, 3'b000, f7, 64'd2, 64'd2);
        flush = fl;
        @(negedge clk);
        check("reject_stall", 128'(stall), 128'(0));
        tick;
        mul_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        check("reject_idle", 128'({hold_flag, stall}), 128'(3'b000));
        tick;
    endtask

    initial begin
        #500000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got no end of test expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int cnt;
        rst_n = 1'b0; mul_valid = 1'b0; flush = 1'b0; end_in = 1'b0;
        rs1 = '0; rs2 = '0; rd_addr = '0; opcode = '0; funct3 = '0; funct7 = '0;
        product = '0; wr_addr = '0; op_in = '0; f3_in = '0; last_wb = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outs", 128'({hold_flag, stall, wb_valid, wb_addr, wb_data, tmo_err}), 128'(0));
        check("reset_operands", {mcand_out, mplier_out}, 128'(0));
        rst_n = 1'b1;
        tick;

        // Directed results.
        last_wb = '0;
        do_op(5'd5, OP, 3'b000, 64'd7, 64'hFFFFFFFFFFFFFFFD, 2);
        check("mul_7x_neg3", 128'(last_wb), 128'(64'hFFFFFFFFFFFFFFEB));
        last_wb = '0;
        do_op(5'd6, OP, 3'b011, 64'h1_0000_0000, 64'h1_0000_0000, 1);
        check("mulhu_carry", 128'(last_wb), 128'(64'd1));
        last_wb = '0;
        do_op(5'd7, OP32, 3'b000, 64'h1_0000, 64'h8000, 0);
        check("mulw_sext", 128'(last_wb), 128'(64'hFFFFFFFF80000000));
        do_op(5'd0, OP, 3'b000, 64'd9, 64'd9, 1);
        do_op(5'd8, OP32, 3'b001, 64'd9, 64'd9, 1);
        do_op(5'd11, OP, 3'b000, 64'd12, 64'd13, 0);
        do_op(5'd12, OP, 3'b001, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0);
        do_op(5'd13, OP, 3'b010, 64'd5, 64'd6, TIMEOUT - 1);

        reject(7'b0010011, F7M, 1'b0);
        reject(OP, 7'b0100000, 1'b0);
        reject(OP, F7M, 1'b1);

        flush_op(2, 1'b0);
        flush_op(0, 1'b1);

        // Multiplier that never answers.
        issue(5'd4, OP, 3'b000, F7M, 64'd1, 64'd1);
        @(negedge clk);
        tick;
        mul_valid = 1'b0;
        @(negedge clk);
        check("err_before", 128'(tmo_err), 128'(0));
        tick;
        cnt = 0;
        for (int i = 0; i < TIMEOUT + 8; i++) begin
            @(negedge clk);
            if (hold_flag != 2'b10) break;
            cnt++;
            tick;
        end
        check("timeout_cycles", 128'(cnt), 128'(TIMEOUT));
        check("timeout_err", 128'(tmo_err), 128'(1));
        check("timeout_idle", 128'({hold_flag, stall, wb_valid}), 128'(0));
        tick;
        do_op(5'd14, OP, 3'b000, 64'd2, 64'd3, 1);
        check("err_sticky", 128'(tmo_err), 128'(1));

        // Reset while waiting, followed by a stale end pulse.
        launch(5'd15, OP, 3'b000, 64'd4, 64'd4);
        tick;
        rst_n = 1'b0;
        tick;
        @(negedge clk);
        check("rst_outs", 128'({hold_flag, stall, wb_valid, wb_addr, wb_data, tmo_err}), 128'(0));
        rst_n = 1'b1;
        tick;
        end_in  = 1'b1;
        product = prod(3'b000, 64'd4, 64'd4);
        wr_addr = 5'd15;
        op_in   = OP;
        f3_in   = 3'b000;
        tick;
        end_in = 1'b0;
        @(negedge clk);
        check("late_end_idle", 128'({hold_flag, stall, wb_valid}), 128'(0));
        tick;

        // Randomized traffic, back to back.
        for (int n = 0; n < 40; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic [4:0] rd;
            if ($urandom_range(0, 9) == 0) begin
                flush_op($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end else begin
                op = ($urandom_range(0, 3) == 0) ? OP32 : OP;
                f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
                if (op == OP32 && $urandom_range(0, 2) != 0) f3 = 3'b000;
                rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                do_op(rd, op, f3, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                      $urandom_range(0, 6));
            end
        end

        repeat (2) tick;
        check("final_queue", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
